// File: rtl/flex_serial_crc_if.sv
// Frame-control and result bundle for flex_serial_crc.
// The master drives the bit stream and strobes; the slave returns the CRC status.
interface flex_serial_crc_if #(
    parameter int CRC_WIDTH = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 shift_enable;
    logic                 serial_in;
    logic                 eop;
    logic                 emit;
    logic [CRC_WIDTH-1:0] crc_value;
    logic                 crc_ok;
    logic [CNT_WIDTH-1:0] bit_count;
    logic                 serial_out;
    logic                 serial_out_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output start, shift_enable, serial_in, eop, emit,
        input  crc_value, crc_ok, bit_count, serial_out, serial_out_valid, busy, done
    );

    modport slave (
        input  start, shift_enable, serial_in, eop, emit,
        output crc_value, crc_ok, bit_count, serial_out, serial_out_valid, busy, done
    );
endinterface

// File: rtl/flex_serial_crc.sv
// Parametrised MSB-first bit-serial CRC: accumulates a frame, checks the residue
// at end of frame and can shift the complemented CRC back out.
module flex_serial_crc #(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] POLY      = 16'h8005,
    parameter logic [CRC_WIDTH-1:0] INIT      = '1,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = '1,
    parameter logic [CRC_WIDTH-1:0] RESIDUE   = 16'h800D,
    parameter int                   CNT_WIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    flex_serial_crc_if.slave  bus
);
    localparam int IDX_W = $clog2(CRC_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    state_t               r_state;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_ok;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_fb;
    logic [CRC_WIDTH-1:0] w_crc_nxt;
    logic [CRC_WIDTH-1:0] w_crc_acc;
    logic [CRC_WIDTH-1:0] w_final;
    logic [IDX_W-1:0]     w_bit_sel;

    assign w_fb      = r_crc[CRC_WIDTH-1] ^ bus.serial_in;
    assign w_crc_nxt = {r_crc[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    // Residue is judged on the register including a bit accepted alongside eop.
    assign w_crc_acc = bus.shift_enable ? w_crc_nxt : r_crc;
    assign w_final   = r_crc ^ XOR_OUT;
    assign w_bit_sel = IDX_LAST - r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_crc   <= INIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ok    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start) begin
                r_state <= ACCUM;
                r_crc   <= INIT;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_ok    <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ACCUM: begin
                        if (bus.shift_enable) begin
                            r_crc <= w_crc_nxt;
                            if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
                        end
                        if (bus.eop) begin
                            r_ok <= (w_crc_acc == RESIDUE);
                            if (bus.emit) begin
                                r_state <= EMIT;
                            end else begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        if (bus.shift_enable) begin
                            if (r_idx == IDX_LAST) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.crc_value        = w_final;
    assign bus.crc_ok           = r_ok;
    assign bus.bit_count        = r_cnt;
    assign bus.serial_out_valid = (r_state == EMIT);
    assign bus.serial_out       = (r_state == EMIT) ? w_final[w_bit_sel] : 1'b0;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
endmodule
